serial_comparator: RTL

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator_pkg.sv | 16 +
 rtl/serial_comparator_cmp_result_decode.sv | 24 ++
 rtl/serial_comparator.sv | 99 +++++++++
 3 files changed

// File: rtl/serial_comparator_pkg.sv
// Shared types for the serial comparator family: FSM states and compare result.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } result_t;

endpackage

// File: rtl/serial_comparator_cmp_result_decode.sv
// Combinational one-hot decode of a compare result into gt/lt/eq flags.
module cmp_result_decode
  import serial_comparator_pkg::*;
(
  input  result_t result,
  output logic    gt_c,
  output logic    lt_c,
  output logic    eq_c
);

  // One-hot decode; unused encodings produce all-zero flags
  always_comb begin
    gt_c = 1'b0;
    lt_c = 1'b0;
    eq_c = 1'b0;
    case (result)
      GT:      gt_c = 1'b1;
      LT:      lt_c = 1'b1;
      EQ:      eq_c = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_comparator.sv
// MSB-first serial magnitude comparator with stall, abort and one-cycle done pulse.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic A_gt_B,
  output logic A_lt_B,
  output logic A_equal_B
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            decided;
  result_t         pending;
  result_t         pending_nxt;
  logic            gt_c;
  logic            lt_c;
  logic            eq_c;

  // Result after folding in the current bit pair; only the first difference counts
  always_comb begin
    pending_nxt = pending;
    if (!decided && (a_bit != b_bit)) begin
      pending_nxt = a_bit ? GT : LT;
    end
  end

  // Decode the final result so the flags can be loaded together with the DONE entry
  cmp_result_decode u_decode (
    .result (pending_nxt),
    .gt_c   (gt_c),
    .lt_c   (lt_c),
    .eq_c   (eq_c)
  );

  // Frame FSM, bit counter, result tracking and registered result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      decided   <= 1'b0;
      pending   <= EQ;
      A_gt_B    <= 1'b0;
      A_lt_B    <= 1'b0;
      A_equal_B <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= SHIFT;
            cnt     <= '0;
            decided <= 1'b0;
            pending <= EQ;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else if (bit_valid) begin
            cnt     <= cnt + CW'(1);
            pending <= pending_nxt;
            if (a_bit != b_bit) begin
              decided <= 1'b1;
            end
            if (cnt == CW'(WIDTH - 1)) begin
              state     <= DONE;
              A_gt_B    <= gt_c;
              A_lt_B    <= lt_c;
              A_equal_B <= eq_c;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are direct decodes of the state register
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
